// File: rtl/fsk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsk_pkg
// Description : Rate classes, bin boundaries and FSM states shared by the
//               FSK rate detector.
// Revision    : 1.0 - initial release
// ============================================================================
package fsk_pkg;

    typedef enum logic [2:0] {
        CLS_N32 = 3'd0,
        CLS_N16 = 3'd1,
        CLS_N8  = 3'd2,
        CLS_N4  = 3'd3,
        CLS_INV = 3'd4
    } rate_cls_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Lower bounds of each half-period bin; c_INV_LO is the first invalid length
    localparam int unsigned c_INV_LO = 24;
    localparam int unsigned c_N32_LO = 12;
    localparam int unsigned c_N16_LO = 6;
    localparam int unsigned c_N8_LO  = 3;
    localparam int unsigned c_N4_LEN = 2;

    function automatic rate_cls_t classify(input int unsigned m);
        rate_cls_t c;
        if (m >= c_INV_LO)      c = CLS_INV;
        else if (m >= c_N32_LO) c = CLS_N32;
        else if (m >= c_N16_LO) c = CLS_N16;
        else if (m >= c_N8_LO)  c = CLS_N8;
        else if (m == c_N4_LEN) c = CLS_N4;
        else                    c = CLS_INV;
        return c;
    endfunction

    function automatic logic [3:0] cls_onehot(input rate_cls_t c);
        logic [3:0] oh;
        case (c)
            CLS_N32: oh = 4'b0001;
            CLS_N16: oh = 4'b0010;
            CLS_N8:  oh = 4'b0100;
            CLS_N4:  oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsk_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : fsk_edge_sync
// Description : Two-flop synchronizer followed by a registered any-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module fsk_edge_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic i_sig_in,
    output logic o_edge
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_edge;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= i_sig_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_edge  <= r_sync2 ^ r_prev;
        end
    end

    assign o_edge = r_edge;

endmodule
`default_nettype wire

// File: rtl/fsk_rate_detect.sv
`default_nettype none
// ============================================================================
// Module      : fsk_rate_detect
// Description : Measures the half-period of an FSK tone and recovers the
//               one-hot divider rate that produced it.
// Revision    : 1.0 - initial release
// ============================================================================
module fsk_rate_detect
    import fsk_pkg::*;
#(
    parameter int CW        = 6,
    parameter int TIMEOUT   = 63,
    parameter int MATCH_CNT = 2
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          sig_in,
    output logic [3:0]    sel_out,
    output logic          sel_valid,
    output logic          sel_change,
    output logic [CW-1:0] half_len,
    output logic          meas_stb
);

    localparam int              c_MW      = $clog2(MATCH_CNT + 1);
    localparam logic [CW-1:0]   c_TIMEOUT = CW'(TIMEOUT);
    localparam logic [CW-1:0]   c_ONE     = CW'(1);
    localparam logic [c_MW-1:0] c_MATCH   = c_MW'(MATCH_CNT);

    logic            w_edge;
    state_t          r_state,     w_state_nxt;
    logic [CW-1:0]   r_cnt,       w_cnt_nxt;
    rate_cls_t       r_cand,      w_cand_nxt;
    rate_cls_t       r_lock_cls,  w_lock_nxt;
    logic [c_MW-1:0] r_match,     w_match_nxt;
    logic [3:0]      r_sel_out,   w_sel_nxt;
    logic            r_sel_valid, w_valid_nxt;
    logic            r_sel_chg,   w_chg_nxt;
    logic [CW-1:0]   r_half_len,  w_len_nxt;
    logic            r_meas_stb,  w_stb_nxt;
    rate_cls_t       w_cls;
    logic [c_MW-1:0] w_match_inc;

    fsk_edge_sync u_edge_sync (
        .clk_in   (clk_in),
        .rst      (rst),
        .i_sig_in (sig_in),
        .o_edge   (w_edge)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cand      <= CLS_INV;
            r_lock_cls  <= CLS_INV;
            r_match     <= '0;
            r_sel_out   <= '0;
            r_sel_valid <= 1'b0;
            r_sel_chg   <= 1'b0;
            r_half_len  <= '0;
            r_meas_stb  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cand      <= w_cand_nxt;
            r_lock_cls  <= w_lock_nxt;
            r_match     <= w_match_nxt;
            r_sel_out   <= w_sel_nxt;
            r_sel_valid <= w_valid_nxt;
            r_sel_chg   <= w_chg_nxt;
            r_half_len  <= w_len_nxt;
            r_meas_stb  <= w_stb_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt == c_TIMEOUT) ? r_cnt : r_cnt + c_ONE;
        w_cand_nxt  = r_cand;
        w_lock_nxt  = r_lock_cls;
        w_match_nxt = r_match;
        w_sel_nxt   = r_sel_out;
        w_valid_nxt = r_sel_valid;
        w_chg_nxt   = 1'b0;
        w_len_nxt   = r_half_len;
        w_stb_nxt   = 1'b0;
        w_cls       = classify(32'(r_cnt));
        // A stale candidate after an invalid measurement restarts from a count of 1
        w_match_inc = (w_cls == r_cand) ? r_match + c_MW'(1) : c_MW'(1);

        if (w_edge) begin
            w_cnt_nxt = c_ONE;
        end

        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_state_nxt = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                if (w_edge) begin
                    w_len_nxt = r_cnt;
                    w_stb_nxt = 1'b1;
                    if (w_cls == CLS_INV) begin
                        w_match_nxt = '0;
                        w_state_nxt = MEASURE;
                        w_sel_nxt   = '0;
                        w_valid_nxt = 1'b0;
                    end else if (r_state == LOCKED && w_cls == r_lock_cls) begin
                        w_match_nxt = '0;
                    end else begin
                        w_cand_nxt = w_cls;
                        if (w_match_inc == c_MATCH) begin
                            w_state_nxt = LOCKED;
                            w_lock_nxt  = w_cls;
                            w_sel_nxt   = cls_onehot(w_cls);
                            w_valid_nxt = 1'b1;
                            w_chg_nxt   = 1'b1;
                            w_match_nxt = '0;
                        end else begin
                            w_match_nxt = w_match_inc;
                        end
                    end
                end else if (r_cnt == c_TIMEOUT) begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_match_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        sel_out    = r_sel_out;
        sel_valid  = r_sel_valid;
        sel_change = r_sel_chg;
        half_len   = r_half_len;
        meas_stb   = r_meas_stb;
    end

endmodule
`default_nettype wire

// File: tb/tb_fsk_rate_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsk_rate_detect
// Description : Directed self-checking bench for fsk_rate_detect.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsk_rate_detect;

    localparam int CW = 6;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          sig_in;
    logic [3:0]    sel_out;
    logic          sel_valid;
    logic          sel_change;
    logic [CW-1:0] half_len;
    logic          meas_stb;

    int vec_cnt   = 0;
    int err_cnt   = 0;
    int stb_cnt   = 0;
    int chg_cnt   = 0;
    int valid_cyc = 0;
    int last_len  = 0;

    fsk_rate_detect #(
        .CW        (CW),
        .TIMEOUT   (63),
        .MATCH_CNT (2)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig_in),
        .sel_out    (sel_out),
        .sel_valid  (sel_valid),
        .sel_change (sel_change),
        .half_len   (half_len),
        .meas_stb   (meas_stb)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (meas_stb) begin
            stb_cnt  <= stb_cnt + 1;
            last_len <= int'(half_len);
        end
        if (sel_change) chg_cnt <= chg_cnt + 1;
        if (sel_valid)  valid_cyc <= valid_cyc + 1;
    end

    task automatic chk_eq(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Toggle the tone, then hold it for n clock cycles
    task automatic tog(input int n);
        sig_in = ~sig_in;
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int stb_base;
        int chg_base;
        int v_base;

        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rst = 1'b0;

        chk_eq("rst_sel_out",    int'(sel_out),    0);
        chk_eq("rst_sel_valid",  int'(sel_valid),  0);
        chk_eq("rst_sel_change", int'(sel_change), 0);
        chk_eq("rst_half_len",   int'(half_len),   0);
        chk_eq("rst_meas_stb",   int'(meas_stb),   0);

        // Lock to N32 from a 16-cycle half-period
        chg_base = chg_cnt;
        tog(16); tog(16); tog(16);
        chk_eq("n32_stb_count", stb_cnt, 2);
        chk_eq("n32_half_len",  last_len, 16);
        chk_eq("n32_sel_out",   int'(sel_out), 1);
        chk_eq("n32_sel_valid", int'(sel_valid), 1);
        chk_eq("n32_chg_count", chg_cnt - chg_base, 1);

        // Switch to N4: hold after first short half-period, switch after second
        chg_base = chg_cnt;
        tog(2);
        tog(2);
        tog(2);
        chk_eq("n4_first_hold", int'(sel_out), 1);
        chk_eq("n4_first_chg",  chg_cnt - chg_base, 0);
        tog(2);
        chk_eq("n4_switch",     int'(sel_out), 8);
        tog(2); tog(2);
        chk_eq("n4_chg_count",  chg_cnt - chg_base, 1);
        chk_eq("n4_half_len",   last_len, 2);
        chk_eq("n4_sel_valid",  int'(sel_valid), 1);

        // Move to N16, then hold the tone static until timeout
        tog(8); tog(8); tog(8); tog(8);
        chk_eq("n16_sel_out", int'(sel_out), 2);
        stb_base = stb_cnt;
        repeat (80) @(posedge clk_in);
        #1;
        chk_eq("to_sel_out",   int'(sel_out), 0);
        chk_eq("to_sel_valid", int'(sel_valid), 0);
        chk_eq("to_no_stb",    stb_cnt - stb_base, 0);

        // Alternating 8/16 half-periods from IDLE never lock
        stb_base = stb_cnt;
        v_base   = valid_cyc;
        tog(8); tog(16); tog(8); tog(16); tog(8);
        chk_eq("alt_stb_count",  stb_cnt - stb_base, 4);
        chk_eq("alt_valid_cyc",  valid_cyc - v_base, 0);
        chk_eq("alt_half_len",   last_len, 16);
        chk_eq("alt_sel_out",    int'(sel_out), 0);
        repeat (80) @(posedge clk_in);
        #1;

        // Lock to N8, glitch with a 1-cycle half-period, relock
        tog(4); tog(4); tog(4);
        chk_eq("n8_sel_out", int'(sel_out), 4);
        tog(4);
        tog(1);
        tog(4);
        chk_eq("gl_sel_valid", int'(sel_valid), 0);
        chk_eq("gl_sel_out",   int'(sel_out), 0);
        chk_eq("gl_half_len",  int'(half_len), 1);
        tog(4);
        chk_eq("gl_one_match", int'(sel_valid), 0);
        tog(4);
        chk_eq("gl_relock_sel",   int'(sel_out), 4);
        chk_eq("gl_relock_valid", int'(sel_valid), 1);

        // Asynchronous reset while locked
        @(posedge clk_in);
        #3 rst = 1'b1;
        sig_in = 1'b0;
        #1;
        chk_eq("arst_sel_out",   int'(sel_out), 0);
        chk_eq("arst_sel_valid", int'(sel_valid), 0);
        chk_eq("arst_half_len",  int'(half_len), 0);
        chk_eq("arst_meas_stb",  int'(meas_stb), 0);
        repeat (3) @(posedge clk_in);
        #1 rst = 1'b0;
        stb_base = stb_cnt;
        chg_base = chg_cnt;
        tog(4); tog(4);
        chk_eq("rl_two_edges_valid", int'(sel_valid), 0);
        tog(4);
        chk_eq("rl_sel_out",   int'(sel_out), 4);
        chk_eq("rl_sel_valid", int'(sel_valid), 1);
        repeat (2) @(posedge clk_in);
        #1;
        chk_eq("rl_stb_count", stb_cnt - stb_base, 2);
        chk_eq("rl_chg_count", chg_cnt - chg_base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fsk_rate_detect.md
Name: fsk_rate_detect

Overview:
- Receive-side counterpart of the selectable FSK clock divider (divide-by-32/16/8/4 from one-hot SW).
- Takes the divided square wave as an input tone, measures its half-period in clk_in cycles, and recovers which one-hot rate selection produced it.
- Sits in the demodulator path after the carrier/tone input; drives downstream bit decision logic with a confirmed rate code.

Parameters:
- CW, 6, width of half-period counter and half_len output
- TIMEOUT, 63, counter value at which a missing edge drops lock (must be < 2**CW)
- MATCH_CNT, 2, consecutive same-class measurements required to lock or to switch class

Ports:
- clk_in  input  1  system clock; same clock that drives the transmit-side divider
- rst  input  1  asynchronous, active-high reset
- sig_in  input  1  incoming FSK square wave, asynchronous to clk_in
- sel_out  output  4  recovered one-hot rate: bit0=N32, bit1=N16, bit2=N8, bit3=N4; 0 when unlocked
- sel_valid  output  1  high while locked
- sel_change  output  1  one-cycle pulse when sel_out changes between two non-zero values or on first lock
- half_len  output  CW  last measured half-period in clk_in cycles
- meas_stb  output  1  one-cycle pulse when half_len updates

Behaviour:
- One clock (clk_in); reset is asynchronous and active-high (rst). All flops clear on rst: sel_out=0, sel_valid=0, sel_change=0, half_len=0, meas_stb=0, state=IDLE, counters=0, sync flops=0.
- Input path: 2-flop synchronizer, then edge detector (rising OR falling) -> edge pulse 3 cycles after sig_in transition; constant latency, so measurements are exact.
- Counter cnt: on edge, cnt<=1; otherwise increments, saturating at TIMEOUT. Measured half-period = cnt value on the edge cycle. Divide-by-N source gives exactly N/2.
- Classification of a measurement m: 12..23 -> N32; 6..11 -> N16; 3..5 -> N8; 2 -> N4; 0, 1, or >=24 -> INVALID.
- States:
  IDLE: waiting for first edge; no measurement is taken; first edge arms cnt -> MEASURE.
  MEASURE: each edge yields a measurement, with half_len<=m and meas_stb pulse on the following cycle. Same class as candidate -> match count+1; different valid class -> candidate<=class, count<=1; INVALID -> count<=0. When count reaches MATCH_CNT -> LOCKED, sel_out<=candidate, sel_valid<=1, sel_change pulse.
  LOCKED: measurement equal to sel_out class -> no change. Different valid class -> tracked as candidate; sel_out/sel_valid hold until MATCH_CNT consecutive matches, then sel_out switches with sel_change pulse. INVALID -> MEASURE, sel_out<=0, sel_valid<=0, count<=0.
- Timeout: cnt reaching TIMEOUT in MEASURE or LOCKED -> IDLE, sel_out<=0, sel_valid<=0, count<=0; no meas_stb.
- Output timing: lock outputs update on the cycle after the completing edge, together with meas_stb.
- Simultaneous edge and timeout in the same cycle: edge wins (measurement = TIMEOUT, classified INVALID).
- rst mid-operation: immediate clear; re-lock requires 1 + MATCH_CNT edges.
- sel_out is always 0 or exactly one-hot.

Decomposition:
- fsk_pkg: rate class enum (CLS_N32, CLS_N16, CLS_N8, CLS_N4, CLS_INV), bin boundary constants (12, 24, 6, 3, 2), class-to-one-hot function, state enum (IDLE, MEASURE, LOCKED).
- Sub-module fsk_edge_sync: 2-flop synchronizer plus any-edge pulse generator, with clk_in and rst.

Test Plan:
- Reset, then sig_in toggling every 16 cycles -> meas_stb with half_len=16 after edges 2 and 3; sel_out=4'b0001, sel_valid=1, sel_change pulse one cycle after edge 3.
- Locked at N32, switch source to toggling every 2 cycles -> sel_out stays 0001 after the first N4 measurement, becomes 4'b1000 after the second, with one sel_change pulse.
- Locked at N16 (toggle every 8), hold sig_in static -> cnt saturates at 63; sel_out=0, sel_valid=0, state IDLE; no meas_stb.
- Locked at N8 (toggle every 4), inject one glitch pair giving m=1 -> sel_valid drops to 0 one cycle after that edge; re-locks to 0100 after 2 good measurements.
- Alternating measurements 8, 16, 8, 16 -> never locks; sel_valid stays 0; meas_stb on every edge after the first.
- Assert rst during LOCKED -> all outputs 0 immediately (asynchronous); after release, lock again needs 3 edges.
